// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: SPI initiator, mode 0, MSB first, one ss-low frame per
// accepted tx word. The word shifted in on miso during the frame is returned
// on rx_data with a single-cycle rx_valid pulse when ss rises.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   tx_data, tx_valid   word to send; accepted when tx_valid && tx_ready
//   tx_ready            high only while idle
//   rx_data, rx_valid   word captured during the last completed frame, update pulse
//   busy                high whenever a frame (including its idle gap) is in progress
//   sck, mosi, ss       SPI pins driven by this block (sck idles low, ss active low)
//   miso                SPI data in, asynchronous to clk
module spi_ctrl_master #(
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 2,
    parameter int SS_SETUP   = 2,
    parameter int SS_HOLD    = 2,
    parameter int SS_IDLE    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    output logic                  ss,
    input  logic                  miso
);

    // One shared phase timer covers every timed state; size it for the longest.
    localparam int M1   = (SS_SETUP > 2 * CLK_DIV) ? SS_SETUP : 2 * CLK_DIV;
    localparam int M2   = (SS_HOLD > SS_IDLE) ? SS_HOLD : SS_IDLE;
    localparam int TMAX = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(TMAX);
    localparam int BW   = $clog2(FRAME_BITS + 1);

    localparam logic [TW-1:0] SETUP_LAST = TW'(SS_SETUP - 1);
    localparam logic [TW-1:0] LOW_LAST   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HIGH_LAST  = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(SS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(SS_IDLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] tx_next;
    logic [1:0]            miso_sync;

    assign tx_next = tx_sr << 1;

    // miso comes from outside the clk domain; two flops before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ss       <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        tx_sr    <= tx_data;
                        bit_cnt  <= '0;
                        timer    <= '0;
                        ss       <= 1'b0;
                        mosi     <= tx_data[FRAME_BITS-1];
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer == SETUP_LAST) begin
                        timer <= '0;
                        state <= SHIFT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHIFT: begin
                    // timer 0..CLK_DIV-1 is the sck-low half, the rest the high half.
                    if (timer == LOW_LAST) begin
                        sck   <= 1'b1;
                        timer <= timer + 1'b1;
                    end else if (timer == HIGH_LAST) begin
                        // Last clk of the high half: sample, fall, advance.
                        sck     <= 1'b0;
                        rx_sr   <= (rx_sr << 1) | FRAME_BITS'(miso_sync[1]);
                        bit_cnt <= bit_cnt + 1'b1;
                        timer   <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            mosi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            tx_sr <= tx_next;
                            mosi  <= tx_next[FRAME_BITS-1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        timer    <= '0;
                        ss       <= 1'b1;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        state    <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer    <= '0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
